// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file. It decodes reads for id, executes the
// CSRRW/CSRRS/CSRRC write op for wb, owns the 64-bit mcycle/minstret counters,
// applies trap/mret side effects, and synchronises the interrupt lines into mip
// to drive a prioritised interrupt request.
// Optional feature macro: CSR_INSTRET_EN builds minstret/instret. Without it,
// those addresses read 0, stay legal and ignore writes.
module csr_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [XLEN-1:0] HARTID    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     id_raddr,
    output logic [XLEN-1:0] id_rdata,
    output logic            id_illegal,
    input  logic            wb_we,
    input  logic [11:0]     wb_waddr,
    input  logic [1:0]      wb_op,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            instret_inc,
    input  logic            irq_ext,
    input  logic            irq_tmr,
    input  logic            irq_sw,
    output logic            int_req,
    output logic [XLEN-1:0] int_cause,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            global_int_en
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NONE  = 2'b11;

    // The *h halves only exist when a counter needs two reads.
    localparam bit HAS_HI = (XLEN == 32);

`ifdef CSR_INSTRET_EN
    localparam bit INSTRET_BUILT = 1'b1;
`else
    localparam bit INSTRET_BUILT = 1'b0;
`endif

    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            st_mie_q, st_mie_d;
    logic            st_mpie_q, st_mpie_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_val;
    logic [2:0]      irq_s1_q, irq_s2_q;     // {ext, tmr, sw}

    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] mip_rd;
    logic [XLEN-1:0] wr_old;
    logic [XLEN-1:0] wr_val;
    logic [XLEN-1:0] byp_val;
    logic [XLEN-1:0] pend;
    logic            wr_en;

    function automatic logic csr_legal(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
            A_MIP, A_MHARTID, A_MCYCLE, A_MINSTRET, A_CYCLE, A_INSTRET:
                return 1'b1;
            A_MCYCLEH, A_MINSTRETH, A_CYCLEH, A_INSTRETH:
                return HAS_HI;
            default:
                return 1'b0;
        endcase
    endfunction

    function automatic logic csr_writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
            A_MCYCLE:    return 1'b1;
            A_MCYCLEH:   return HAS_HI;
            A_MINSTRET:  return INSTRET_BUILT;
            A_MINSTRETH: return HAS_HI && INSTRET_BUILT;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] csr_value(input logic [11:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        case (a)
            A_MSTATUS:              v = mstatus_rd;
            A_MIE:                  v = mie_q;
            A_MTVEC:                v = mtvec_q;
            A_MSCRATCH:             v = mscratch_q;
            A_MEPC:                 v = mepc_q;
            A_MCAUSE:               v = mcause_q;
            A_MTVAL:                v = mtval_q;
            A_MIP:                  v = mip_rd;
            A_MHARTID:              v = HARTID;
            A_MCYCLE, A_CYCLE:      v = mcycle_q[XLEN-1:0];
            A_MCYCLEH, A_CYCLEH:    if (HAS_HI) v = XLEN'(mcycle_q[63:32]);
            A_MINSTRET, A_INSTRET:  v = minstret_val[XLEN-1:0];
            A_MINSTRETH, A_INSTRETH: if (HAS_HI) v = XLEN'(minstret_val[63:32]);
            default:                v = '0;
        endcase
        return v;
    endfunction

    // Read views of mstatus (MPP hardwired to M) and mip.
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = st_mpie_q;
        mstatus_rd[3]     = st_mie_q;
        mip_rd            = '0;
        mip_rd[11]        = irq_s2_q[2];
        mip_rd[7]         = irq_s2_q[1];
        mip_rd[3]         = irq_s2_q[0];
    end

    // Read-modify-write value for the wb op.
    always_comb begin
        wr_old = csr_value(wb_waddr);
        case (wb_op)
            OP_WRITE: wr_val = wb_wdata;
            OP_SET:   wr_val = wr_old | wb_wdata;
            OP_CLEAR: wr_val = wr_old & ~wb_wdata;
            default:  wr_val = wr_old;
        endcase
    end

    // A write only lands when nothing with higher priority owns this cycle.
    assign wr_en = wb_we && !trap_valid && !mret_valid && (wb_op != OP_NONE)
                   && csr_writable(wb_waddr);

    // id read port with bypass of the value wb is committing this cycle.
    always_comb begin
        byp_val = wr_val;
        if (wb_waddr == A_MSTATUS) begin
            byp_val        = '0;
            byp_val[12:11] = 2'b11;
            byp_val[7]     = wr_val[7];
            byp_val[3]     = wr_val[3];
        end
        if (wr_en && (wb_waddr == id_raddr)) id_rdata = byp_val;
        else                                 id_rdata = csr_value(id_raddr);
    end

    assign id_illegal = !csr_legal(id_raddr);

    // CSR next state: trap beats mret beats the wb write.
    always_comb begin
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        if (trap_valid) begin
            mepc_d    = trap_pc;
            mcause_d  = trap_cause;
            mtval_d   = trap_tval;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end else if (mret_valid) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (wb_waddr)
                A_MSTATUS: begin
                    st_mie_d  = wr_val[3];
                    st_mpie_d = wr_val[7];
                end
                A_MIE:      mie_d      = wr_val;
                A_MTVEC:    mtvec_d    = wr_val;
                A_MSCRATCH: mscratch_d = wr_val;
                A_MEPC:     mepc_d     = wr_val;
                A_MCAUSE:   mcause_d   = wr_val;
                A_MTVAL:    mtval_d    = wr_val;
                default:    ;
            endcase
        end
    end

    // mcycle: free-running, a write to either half replaces the increment.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (wr_en && (wb_waddr == A_MCYCLE)) begin
            if (HAS_HI) mcycle_d = {mcycle_q[63:32], wr_val[31:0]};
            else        mcycle_d = 64'(wr_val);
        end else if (wr_en && (wb_waddr == A_MCYCLEH)) begin
            mcycle_d = {wr_val[31:0], mcycle_q[31:0]};
        end
    end

    // CSR and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mcycle_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mcycle_q   <= mcycle_d;
        end
    end

    // Two-flop synchroniser for the asynchronous interrupt levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
        end else begin
            irq_s1_q <= {irq_ext, irq_tmr, irq_sw};
            irq_s2_q <= irq_s1_q;
        end
    end

`ifdef CSR_INSTRET_EN
    logic [63:0] minstret_q, minstret_d;

    // minstret: counts retirements, a write to either half replaces the increment.
    always_comb begin
        minstret_d = minstret_q + {63'd0, instret_inc};
        if (wr_en && (wb_waddr == A_MINSTRET)) begin
            if (HAS_HI) minstret_d = {minstret_q[63:32], wr_val[31:0]};
            else        minstret_d = 64'(wr_val);
        end else if (wr_en && (wb_waddr == A_MINSTRETH)) begin
            minstret_d = {wr_val[31:0], minstret_q[31:0]};
        end
    end

    // minstret register.
    always_ff @(posedge clk) begin
        if (rst) minstret_q <= '0;
        else     minstret_q <= minstret_d;
    end

    assign minstret_val = minstret_q;
`else
    logic instret_unused;
    assign instret_unused = instret_inc;
    assign minstret_val   = '0;
`endif

    // Interrupt request and cause: MEI > MSI > MTI.
    always_comb begin
        pend      = mip_rd & mie_q;
        int_req   = st_mie_q & (|pend);
        int_cause = '0;
        if (int_req) begin
            int_cause[XLEN-1] = 1'b1;
            if (pend[11])     int_cause[3:0] = 4'd11;
            else if (pend[3]) int_cause[3:0] = 4'd3;
            else              int_cause[3:0] = 4'd7;
        end
    end

    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign global_int_en = st_mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios followed by random
// traffic, all compared against an address-keyed reference model.
`timescale 1ns/1ps
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
    localparam logic [31:0] HARTID    = 32'd5;
`ifdef CSR_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] id_raddr;
    logic [31:0] id_rdata;
    logic        id_illegal;
    logic        wb_we;
    logic [11:0] wb_waddr;
    logic [1:0]  wb_op;
    logic [31:0] wb_wdata;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret_valid, instret_inc;
    logic        irq_ext, irq_tmr, irq_sw;
    logic        int_req;
    logic [31:0] int_cause, mtvec_o, mepc_o;
    logic        global_int_en;

    always #5 clk = ~clk;

    csr_unit #(.XLEN(32), .MTVEC_RST(MTVEC_RST), .HARTID(HARTID)) dut (
        .clk(clk), .rst(rst),
        .id_raddr(id_raddr), .id_rdata(id_rdata), .id_illegal(id_illegal),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_op(wb_op), .wb_wdata(wb_wdata),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret_valid(mret_valid), .instret_inc(instret_inc),
        .irq_ext(irq_ext), .irq_tmr(irq_tmr), .irq_sw(irq_sw),
        .int_req(int_req), .int_cause(int_cause), .mtvec_o(mtvec_o),
        .mepc_o(mepc_o), .global_int_en(global_int_en)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain storage CSRs live in an address-keyed table.
    logic [31:0] m_csr [int];
    bit          m_st_mie, m_st_mpie;
    logic [63:0] m_cycle, m_instret;
    logic [2:0]  m_irq_d1, m_irq_d2;   // {ext, tmr, sw}; d2 is what mip shows

    logic [11:0] pool [0:19] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hF14, 12'hB00,
                                 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                 12'hC02, 12'hC82, 12'h301, 12'h7C0, 12'hFFF};

    function automatic void model_reset();
        m_csr.delete();
        m_csr[12'h304] = 32'd0;
        m_csr[12'h305] = MTVEC_RST;
        m_csr[12'h340] = 32'd0;
        m_csr[12'h341] = 32'd0;
        m_csr[12'h342] = 32'd0;
        m_csr[12'h343] = 32'd0;
        m_st_mie  = 1'b0;
        m_st_mpie = 1'b0;
        m_cycle   = 64'd0;
        m_instret = 64'd0;
        m_irq_d1  = 3'b000;
        m_irq_d2  = 3'b000;
    endfunction

    function automatic logic [31:0] model_mip();
        return (32'(m_irq_d2[2]) << 11) | (32'(m_irq_d2[1]) << 7) | (32'(m_irq_d2[0]) << 3);
    endfunction

    function automatic void model_read(input logic [11:0] a, output logic [31:0] d, output bit legal);
        legal = 1'b1;
        d     = 32'd0;
        if (m_csr.exists(int'(a))) d = m_csr[int'(a)];
        else begin
            case (a)
                12'h300:          d = 32'h1800 | (32'(m_st_mie) << 3) | (32'(m_st_mpie) << 7);
                12'h344:          d = model_mip();
                12'hF14:          d = HARTID;
                12'hB00, 12'hC00: d = m_cycle[31:0];
                12'hB80, 12'hC80: d = m_cycle[63:32];
                12'hB02, 12'hC02: d = INSTRET_ON ? m_instret[31:0] : 32'd0;
                12'hB82, 12'hC82: d = INSTRET_ON ? m_instret[63:32] : 32'd0;
                default:          legal = 1'b0;
            endcase
        end
    endfunction

    function automatic bit model_writable(input logic [11:0] a);
        return m_csr.exists(int'(a)) || a == 12'h300 || a == 12'hB00 || a == 12'hB80
               || (INSTRET_ON && (a == 12'hB02 || a == 12'hB82));
    endfunction

    function automatic bit model_wb_effect(output logic [31:0] nv);
        logic [31:0] old;
        bit          lg;
        model_read(wb_waddr, old, lg);
        case (wb_op)
            2'b00:   nv = wb_wdata;
            2'b01:   nv = old | wb_wdata;
            2'b10:   nv = old & ~wb_wdata;
            default: nv = old;
        endcase
        return wb_we && !trap_valid && !mret_valid && wb_op != 2'b11 && model_writable(wb_waddr);
    endfunction

    task automatic model_clock();
        logic [31:0] nv;
        logic [63:0] cyc, ins;
        bit          eff;
        if (rst) begin
            model_reset();
            return;
        end
        eff = model_wb_effect(nv);
        cyc = m_cycle + 64'd1;
        ins = m_instret + ((INSTRET_ON && instret_inc) ? 64'd1 : 64'd0);
        if (trap_valid) begin
            m_csr[12'h341] = trap_pc;
            m_csr[12'h342] = trap_cause;
            m_csr[12'h343] = trap_tval;
            m_st_mpie = m_st_mie;
            m_st_mie  = 1'b0;
        end else if (mret_valid) begin
            m_st_mie  = m_st_mpie;
            m_st_mpie = 1'b1;
        end else if (eff) begin
            case (wb_waddr)
                12'h300: begin m_st_mie = nv[3]; m_st_mpie = nv[7]; end
                12'hB00: cyc = {m_cycle[63:32], nv};
                12'hB80: cyc = {nv, m_cycle[31:0]};
                12'hB02: ins = {m_instret[63:32], nv};
                12'hB82: ins = {nv, m_instret[31:0]};
                default: m_csr[int'(wb_waddr)] = nv;
            endcase
        end
        m_cycle   = cyc;
        m_instret = ins;
        m_irq_d2  = m_irq_d1;
        m_irq_d1  = {irq_ext, irq_tmr, irq_sw};
    endtask

    task automatic check_outputs();
        logic [31:0] d, nv, pend, cause;
        bit          lg, eff, req;
        model_read(id_raddr, d, lg);
        eff = model_wb_effect(nv);
        if (eff && wb_waddr == id_raddr)
            d = (wb_waddr == 12'h300) ? (32'h1800 | (nv & 32'h88)) : nv;
        check_val("id_rdata", 64'(id_rdata), 64'(d));
        check_val("id_illegal", 64'(id_illegal), 64'(!lg));
        pend  = model_mip() & m_csr[12'h304];
        req   = m_st_mie && (pend != 32'd0);
        cause = !req ? 32'd0 : pend[11] ? 32'h8000_000B : pend[3] ? 32'h8000_0003 : 32'h8000_0007;
        check_val("int_req", 64'(int_req), 64'(req));
        check_val("int_cause", 64'(int_cause), 64'(cause));
        check_val("mtvec_o", 64'(mtvec_o), 64'(m_csr[12'h305]));
        check_val("mepc_o", 64'(mepc_o), 64'(m_csr[12'h341]));
        check_val("global_int_en", 64'(global_int_en), 64'(m_st_mie));
    endtask

    task automatic tick(input bit chk);
        #1;
        if (chk) check_outputs();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_idle();
        wb_we       = 1'b0;
        wb_waddr    = 12'h000;
        wb_op       = 2'b00;
        wb_wdata    = 32'd0;
        trap_valid  = 1'b0;
        trap_cause  = 32'd0;
        trap_pc     = 32'd0;
        trap_tval   = 32'd0;
        mret_valid  = 1'b0;
        instret_inc = 1'b0;
    endtask

    task automatic wb(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        wb_we    = 1'b1;
        wb_waddr = a;
        wb_op    = op;
        wb_wdata = d;
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        id_raddr = a;
        #1;
        check_val(tag, 64'(id_rdata), 64'(exp));
    endtask

    initial begin
        set_idle();
        irq_ext  = 1'b0;
        irq_tmr  = 1'b0;
        irq_sw   = 1'b0;
        id_raddr = 12'h000;
        rst      = 1'b1;
        model_reset();
        @(negedge clk);
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;

        // reset values
        read_chk("rst_mtvec", 12'h305, MTVEC_RST);
        check_val("rst_int_req", 64'(int_req), 64'd0);
        check_val("rst_int_cause", 64'(int_cause), 64'd0);
        check_val("rst_gie", 64'(global_int_en), 64'd0);
        tick(1'b1);
        read_chk("rst_mstatus", 12'h300, 32'h1800);
        tick(1'b1);
        read_chk("mhartid", 12'hF14, HARTID);
        tick(1'b1);
        read_chk("illegal_rdata", 12'h7C0, 32'd0);
        check_val("illegal_flag", 64'(id_illegal), 64'd1);
        tick(1'b1);
        id_raddr = 12'hB02;
        #1 check_val("minstret_legal", 64'(id_illegal), 64'd0);
        tick(1'b1);

        // write / set / clear with same-cycle bypass
        wb(12'h340, 2'b00, 32'hF0F0);
        read_chk("byp_write", 12'h340, 32'hF0F0);
        tick(1'b1);
        wb(12'h340, 2'b01, 32'h000F);
        read_chk("byp_set", 12'h340, 32'hF0FF);
        tick(1'b1);
        wb(12'h340, 2'b10, 32'h00F0);
        read_chk("byp_clear", 12'h340, 32'hF00F);
        tick(1'b1);
        set_idle();
        read_chk("mscratch", 12'h340, 32'hF00F);
        tick(1'b1);

        // trap entry and mret
        wb(12'h300, 2'b01, 32'h8);
        read_chk("mie_set_byp", 12'h300, 32'h1808);
        tick(1'b1);
        set_idle();
        trap_valid = 1'b1;
        trap_pc    = 32'h80;
        trap_cause = 32'd2;
        trap_tval  = 32'h1234;
        tick(1'b1);
        set_idle();
        read_chk("trap_mepc", 12'h341, 32'h80);
        tick(1'b1);
        read_chk("trap_mcause", 12'h342, 32'd2);
        tick(1'b1);
        read_chk("trap_mstatus", 12'h300, 32'h1880);
        tick(1'b1);
        mret_valid = 1'b1;
        tick(1'b1);
        set_idle();
        read_chk("mret_mstatus", 12'h300, 32'h1888);
        tick(1'b1);

        // trap beats a same-cycle wb write
        trap_valid = 1'b1;
        trap_pc    = 32'h100;
        trap_cause = 32'd7;
        wb(12'h341, 2'b00, 32'h44);
        read_chk("conflict_nobyp", 12'h341, 32'h80);
        tick(1'b1);
        set_idle();
        check_val("conflict_mepc", 64'(mepc_o), 64'h100);
        tick(1'b1);

        // counter wrap and write suppression
        wb(12'hB00, 2'b00, 32'hFFFF_FFFF);
        read_chk("mcycle_byp", 12'hB00, 32'hFFFF_FFFF);
        tick(1'b1);
        set_idle();
        read_chk("mcycle_hold", 12'hB00, 32'hFFFF_FFFF);
        tick(1'b1);
        read_chk("mcycle_wrap", 12'hB00, 32'd0);
        tick(1'b1);
        read_chk("mcycleh_carry", 12'hB80, 32'd1);
        tick(1'b1);
        wb(12'hB80, 2'b00, 32'd5);
        read_chk("mcycle_pre", 12'hB00, 32'd2);
        tick(1'b1);
        set_idle();
        read_chk("mcycle_noinc", 12'hB00, 32'd2);
        tick(1'b1);
        read_chk("mcycleh_wr", 12'hB80, 32'd5);
        tick(1'b1);

        // external interrupt through the synchroniser
        wb(12'h304, 2'b00, 32'h800);
        tick(1'b1);
        wb(12'h300, 2'b01, 32'h8);
        tick(1'b1);
        set_idle();
        irq_ext = 1'b1;
        #1 check_val("irq_lat0", 64'(int_req), 64'd0);
        tick(1'b1);
        #1 check_val("irq_lat1", 64'(int_req), 64'd0);
        tick(1'b1);
        #1 check_val("irq_req", 64'(int_req), 64'd1);
        check_val("irq_cause", 64'(int_cause), 64'h8000_000B);
        wb(12'h300, 2'b10, 32'h8);
        tick(1'b1);
        set_idle();
        #1 check_val("irq_masked", 64'(int_req), 64'd0);
        tick(1'b1);

        // priority MEI > MSI > MTI
        wb(12'h304, 2'b00, 32'h888);
        irq_sw  = 1'b1;
        irq_tmr = 1'b1;
        tick(1'b1);
        wb(12'h300, 2'b01, 32'h8);
        tick(1'b1);
        set_idle();
        tick(1'b1);
        #1 check_val("prio_mei", 64'(int_cause), 64'h8000_000B);
        irq_ext = 1'b0;
        tick(1'b1);
        tick(1'b1);
        #1 check_val("prio_msi", 64'(int_cause), 64'h8000_0003);
        irq_sw = 1'b0;
        tick(1'b1);
        tick(1'b1);
        #1 check_val("prio_mti", 64'(int_cause), 64'h8000_0007);
        tick(1'b1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            wb_we       = 1'($urandom_range(0, 1));
            wb_waddr    = pool[$urandom_range(0, 19)];
            wb_op       = 2'($urandom_range(0, 3));
            wb_wdata    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            trap_valid  = ($urandom_range(0, 15) == 0);
            mret_valid  = ($urandom_range(0, 15) == 0);
            trap_pc     = 32'($urandom);
            trap_cause  = 32'($urandom);
            trap_tval   = 32'($urandom);
            instret_inc = 1'($urandom_range(0, 1));
            id_raddr    = ($urandom_range(0, 1) == 1) ? wb_waddr : pool[$urandom_range(0, 19)];
            if ($urandom_range(0, 15) == 0) irq_ext = ~irq_ext;
            if ($urandom_range(0, 15) == 0) irq_tmr = ~irq_tmr;
            if ($urandom_range(0, 15) == 0) irq_sw  = ~irq_sw;
            tick(1'b1);
        end

        // reset during a trap discards the trap
        trap_valid = 1'b1;
        trap_pc    = 32'hDEAD;
        wb(12'h305, 2'b00, 32'h55);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        set_idle();
        #1 check_val("rsttrap_mepc", 64'(mepc_o), 64'd0);
        check_val("rsttrap_mtvec", 64'(mtvec_o), 64'(MTVEC_RST));
        check_val("rsttrap_gie", 64'(global_int_en), 64'd0);
        tick(1'b1);
        tick(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
